// File: rtl/mul_scheduler.sv
// Shared nibble-serial 16x16 unsigned multiplier with a two-requester
// round-robin front end; the product is returned as separate low/high halves.
module mul_scheduler #(
  parameter int CHUNK = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iReq0,
  input  logic [15:0] iA0,
  input  logic [15:0] iB0,
  input  logic        iReq1,
  input  logic [15:0] iA1,
  input  logic [15:0] iB1,
  output logic        oGrant0,
  output logic        oGrant1,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDoneId,
  output logic [15:0] oResultLo,
  output logic [15:0] oResultHi
);

  localparam int STEPS = 16 / CHUNK;
  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);
  localparam logic [15:0] CHUNK_MASK = 16'((32'd1 << CHUNK) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        grant0_q, grant0_d;
  logic        grant1_q, grant1_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;

  logic [8:0]  shamt_s;
  logic [15:0] chunk_s;
  logic [31:0] pp_s;
  logic [31:0] sum_s;
  logic        pick1_s;

  // Partial product for the current multiplier slice, aligned to its weight
  always_comb begin
    shamt_s = 9'(cnt_q) * 9'(CHUNK);
    chunk_s = (b_q >> shamt_s) & CHUNK_MASK;
    pp_s    = ({16'h0000, a_q} * {16'h0000, chunk_s}) << shamt_s;
    sum_s   = acc_q + pp_s;
    // On a tie the requester that was not served last wins
    pick1_s = iReq1 & (~iReq0 | ~last_q);
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant0_d  = 1'b0;
    grant1_d  = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    case (state_q)
      S_IDLE: begin
        if (iReq0 | iReq1) begin
          state_d = S_CALC;
          acc_d   = 32'h0000_0000;
          cnt_d   = 5'd0;
          if (pick1_s) begin
            a_d      = iA1;
            b_d      = iB1;
            owner_d  = 1'b1;
            last_d   = 1'b1;
            grant1_d = 1'b1;
          end else begin
            a_d      = iA0;
            b_d      = iB0;
            owner_d  = 1'b0;
            last_d   = 1'b0;
            grant0_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = sum_s;
        if (cnt_q == LAST_STEP) begin
          state_d   = S_DONE;
          lo_d      = sum_s[15:0];
          hi_d      = sum_s[31:16];
          done_d    = 1'b1;
          done_id_d = owner_q;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 32'h0000_0000;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      lo_q      <= 16'h0000;
      hi_q      <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  assign oGrant0   = grant0_q;
  assign oGrant1   = grant1_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oDoneId   = done_id_q;
  assign oResultLo = lo_q;
  assign oResultHi = hi_q;

endmodule
